// File: rtl/apb_led_sequencer_if.sv
// APB3 bus bundle for the LED sequencer window (16-bit address, 32-bit data).
interface apb_led_sequencer_if;
    logic [15:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverror;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverror
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverror
    );
endinterface

// File: rtl/apb_led_sequencer.sv
// APB3 LED pattern sequencer: steps through up to 8 timed LED patterns,
// one-shot or looping, started by firmware or a debounced switch press.
module apb_led_sequencer #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [23:0] PRESCALE_RESET  = 24'd49999
) (
    input  logic                      io_systemClk,
    input  logic                      io_systemReset,
    apb_led_sequencer_if.slave        apb,
    input  logic                      i_sw,
    output logic [7:0]                o_led,
    output logic                      o_irq
);

    localparam logic [13:0] ADDR_CTRL     = 14'h0000;
    localparam logic [13:0] ADDR_STATUS   = 14'h0001;
    localparam logic [13:0] ADDR_PRESCALE = 14'h0002;
    localparam logic [13:0] ADDR_LAST     = 14'h0003;
    localparam logic [13:0] ADDR_IDLE_LED = 14'h0004;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic        loop_r;
    logic        sw_trig_en_r;
    logic        irq_en_r;
    logic        done_r;
    logic [23:0] prescale_r;
    logic [2:0]  last_r;
    logic [7:0]  idle_led_r;
    logic [7:0]  pat_led_r [8];
    logic [7:0]  pat_dur_r [8];

    logic [2:0]  idx_r;
    logic [2:0]  idx_next_s;
    logic [2:0]  idx_inc_s;
    logic [7:0]  o_led_r;
    logic [7:0]  led_next_s;
    logic        o_irq_r;
    logic [23:0] presc_cnt_r;
    logic [23:0] presc_next_s;
    logic [7:0]  tick_cnt_r;
    logic [7:0]  tick_next_s;

    logic        sw_meta_r;
    logic        sw_sync_r;
    logic        sw_level_r;
    logic        sw_rise_r;
    logic [15:0] sw_cnt_r;

    logic        access_s;
    logic        mapped_s;
    logic [31:0] rd_data_s;
    logic [2:0]  pat_sel_s;
    logic        wr_ctrl_s;
    logic        wr_status_s;
    logic        wr_prescale_s;
    logic        wr_last_s;
    logic        wr_idle_led_s;
    logic        wr_pat_s;
    logic        stop_s;
    logic        start_s;
    logic        busy_s;
    logic        entry_end_s;
    logic        done_set_s;
    logic        done_next_s;
    logic        irq_en_next_s;
    logic        unused_s;

    // A zero duration still holds its entry for one tick.
    function automatic logic [7:0] tick_load(input logic [7:0] dur);
        return (dur == 8'd0) ? 8'd0 : (dur - 8'd1);
    endfunction

    assign access_s      = apb.psel & apb.penable;
    assign pat_sel_s     = apb.paddr[4:2];
    assign wr_ctrl_s     = access_s & apb.pwrite & (apb.paddr[15:2] == ADDR_CTRL);
    assign wr_status_s   = access_s & apb.pwrite & (apb.paddr[15:2] == ADDR_STATUS);
    assign wr_prescale_s = access_s & apb.pwrite & (apb.paddr[15:2] == ADDR_PRESCALE);
    assign wr_last_s     = access_s & apb.pwrite & (apb.paddr[15:2] == ADDR_LAST);
    assign wr_idle_led_s = access_s & apb.pwrite & (apb.paddr[15:2] == ADDR_IDLE_LED);
    assign wr_pat_s      = access_s & apb.pwrite & (apb.paddr[15:5] == 11'h001);

    assign stop_s        = wr_ctrl_s & apb.pwdata[1];
    assign start_s       = ~stop_s & ((wr_ctrl_s & apb.pwdata[0]) | (sw_rise_r & sw_trig_en_r));
    assign busy_s        = (state_r == ST_RUN);
    assign entry_end_s   = (presc_cnt_r == 24'd0) && (tick_cnt_r == 8'd0);
    assign idx_inc_s     = idx_r + 3'd1;

    // A done set on the same edge outranks a W1C clear.
    assign done_next_s   = done_set_s | (done_r & ~(wr_status_s & apb.pwdata[1]));
    assign irq_en_next_s = wr_ctrl_s ? apb.pwdata[4] : irq_en_r;

    assign apb.prdata    = access_s ? rd_data_s : 32'h0000_0000;
    assign apb.pready    = 1'b1;
    assign apb.pslverror = access_s & ~mapped_s;
    assign o_led         = o_led_r;
    assign o_irq         = o_irq_r;
    assign unused_s      = ^{apb.paddr[1:0], apb.pwdata[31:24]};

    // Read-data mux and address map decode.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        mapped_s  = 1'b1;
        case (apb.paddr[15:2])
            ADDR_CTRL:     rd_data_s = {27'h0, irq_en_r, sw_trig_en_r, loop_r, 2'b00};
            ADDR_STATUS:   rd_data_s = {25'h0, idx_r, 2'b00, done_r, busy_s};
            ADDR_PRESCALE: rd_data_s = {8'h00, prescale_r};
            ADDR_LAST:     rd_data_s = {29'h0, last_r};
            ADDR_IDLE_LED: rd_data_s = {24'h0, idle_led_r};
            14'd8, 14'd9, 14'd10, 14'd11, 14'd12, 14'd13, 14'd14, 14'd15:
                rd_data_s = {8'h00, pat_dur_r[pat_sel_s], 8'h00, pat_led_r[pat_sel_s]};
            default:       mapped_s = 1'b0;
        endcase
    end

    // Programmable register file.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            loop_r       <= 1'b0;
            sw_trig_en_r <= 1'b0;
            irq_en_r     <= 1'b0;
            done_r       <= 1'b0;
            prescale_r   <= PRESCALE_RESET;
            last_r       <= 3'd0;
            idle_led_r   <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                pat_led_r[i] <= 8'h00;
                pat_dur_r[i] <= 8'h00;
            end
        end else begin
            if (wr_ctrl_s) begin
                loop_r       <= apb.pwdata[2];
                sw_trig_en_r <= apb.pwdata[3];
                irq_en_r     <= apb.pwdata[4];
            end
            if (wr_prescale_s) begin
                prescale_r <= apb.pwdata[23:0];
            end
            if (wr_last_s) begin
                last_r <= apb.pwdata[2:0];
            end
            if (wr_idle_led_s) begin
                idle_led_r <= apb.pwdata[7:0];
            end
            if (wr_pat_s) begin
                pat_led_r[pat_sel_s] <= apb.pwdata[7:0];
                pat_dur_r[pat_sel_s] <= apb.pwdata[23:16];
            end
            done_r <= done_next_s;
        end
    end

    // Sequencer next-state, entry loading and duration countdown.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        led_next_s   = o_led_r;
        presc_next_s = presc_cnt_r;
        tick_next_s  = tick_cnt_r;
        done_set_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_RUN;
                    idx_next_s   = 3'd0;
                    led_next_s   = pat_led_r[0];
                    presc_next_s = prescale_r;
                    tick_next_s  = tick_load(pat_dur_r[0]);
                end else begin
                    led_next_s   = idle_led_r;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_next_s = ST_IDLE;
                    led_next_s   = idle_led_r;
                end else if (start_s) begin
                    idx_next_s   = 3'd0;
                    led_next_s   = pat_led_r[0];
                    presc_next_s = prescale_r;
                    tick_next_s  = tick_load(pat_dur_r[0]);
                end else if (entry_end_s) begin
                    // idx beyond a lowered LAST ends or wraps just like idx == LAST.
                    if (idx_r < last_r) begin
                        idx_next_s   = idx_inc_s;
                        led_next_s   = pat_led_r[idx_inc_s];
                        presc_next_s = prescale_r;
                        tick_next_s  = tick_load(pat_dur_r[idx_inc_s]);
                    end else if (loop_r) begin
                        idx_next_s   = 3'd0;
                        led_next_s   = pat_led_r[0];
                        presc_next_s = prescale_r;
                        tick_next_s  = tick_load(pat_dur_r[0]);
                    end else begin
                        state_next_s = ST_IDLE;
                        led_next_s   = idle_led_r;
                        done_set_s   = 1'b1;
                    end
                end else if (presc_cnt_r == 24'd0) begin
                    presc_next_s = prescale_r;
                    tick_next_s  = tick_cnt_r - 8'd1;
                end else begin
                    presc_next_s = presc_cnt_r - 24'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                led_next_s   = idle_led_r;
            end
        endcase
    end

    // Sequencer state and registered LED / interrupt outputs.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            state_r     <= ST_IDLE;
            idx_r       <= 3'd0;
            o_led_r     <= 8'h00;
            o_irq_r     <= 1'b0;
            presc_cnt_r <= 24'd0;
            tick_cnt_r  <= 8'd0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            o_led_r     <= led_next_s;
            o_irq_r     <= done_next_s & irq_en_next_s;
            presc_cnt_r <= presc_next_s;
            tick_cnt_r  <= tick_next_s;
        end
    end

    // Switch synchronizer, stability debounce and rising-edge detect.
    always_ff @(posedge io_systemClk) begin
        if (io_systemReset) begin
            sw_meta_r  <= 1'b0;
            sw_sync_r  <= 1'b0;
            sw_level_r <= 1'b0;
            sw_rise_r  <= 1'b0;
            sw_cnt_r   <= 16'd0;
        end else begin
            sw_meta_r <= i_sw;
            sw_sync_r <= sw_meta_r;
            sw_rise_r <= 1'b0;
            if (sw_sync_r == sw_level_r) begin
                sw_cnt_r <= 16'd0;
            end else if (sw_cnt_r == (DEBOUNCE_CYCLES - 16'd1)) begin
                sw_level_r <= sw_sync_r;
                sw_rise_r  <= sw_sync_r;
                sw_cnt_r   <= 16'd0;
            end else begin
                sw_cnt_r <= sw_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_led_sequencer.sv
// Directed, table-driven bench for apb_led_sequencer (DEBOUNCE_CYCLES = 4).
module tb_apb_led_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_sw;
    logic [7:0] o_led;
    logic       o_irq;
    int         n_cmp;
    int         n_bad;
    int         sw_run_cnt = 0;
    int         sw_base;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs[32];

    apb_led_sequencer_if apb ();

    apb_led_sequencer #(
        .DEBOUNCE_CYCLES (16'd4),
        .PRESCALE_RESET  (24'd49999)
    ) dut (
        .io_systemClk   (clk),
        .io_systemReset (rst),
        .apb            (apb),
        .i_sw           (i_sw),
        .o_led          (o_led),
        .o_irq          (o_irq)
    );

    always #5 clk = ~clk;

    // Each switch-started run with a 1-cycle table shows 0x80 for one cycle.
    always @(negedge clk) begin
        if (o_led == 8'h80) sw_run_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All bus tasks are entered on a falling edge and return on one.
    task automatic apb_write(input logic [15:0] addr, input logic [31:0] data);
        apb.paddr   = addr;
        apb.pwdata  = data;
        apb.pwrite  = 1'b1;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        @(negedge clk);
        apb.penable = 1'b1;
        @(negedge clk);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] addr, output logic [31:0] data, output logic err);
        apb.paddr   = addr;
        apb.pwrite  = 1'b0;
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        #1;
        check("setup_prdata", apb.prdata, 32'h0);
        check("setup_pslverror", {31'h0, apb.pslverror}, 32'h0);
        @(negedge clk);
        apb.penable = 1'b1;
        #1;
        data = apb.prdata;
        err  = apb.pslverror;
        check("pready", {31'h0, apb.pready}, 32'h1);
        @(negedge clk);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        logic [31:0] d;
        logic        e;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, d, e);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
                check($sformatf("vec%0d_pslverror", i), {31'h0, e}, {31'h0, vecs[i].err});
            end
        end
    endtask

    task automatic read_status_masked(input string name, input logic [31:0] mask, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(16'h0004, d, e);
        check(name, d & mask, exp);
    endtask

    initial begin
        logic [7:0] exp_led;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        i_sw = 1'b0;
        apb.psel = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite = 1'b0;
        apb.paddr = 16'h0000;
        apb.pwdata = 32'h0;

        // Reset-state reads (0..8), then configuration and read-back (9..31).
        vecs[0]  = '{1'b0, 16'h0000, 32'h0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 16'h0004, 32'h0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0008, 32'h0, 32'h0000_C34F, 1'b0};
        vecs[3]  = '{1'b0, 16'h000C, 32'h0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0010, 32'h0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 16'h0020, 32'h0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 16'h003C, 32'h0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 16'h0014, 32'h0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b0, 16'h0040, 32'h0, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 16'h0008, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[10] = '{1'b0, 16'h0008, 32'h0, 32'h00FF_FFFF, 1'b0};
        vecs[11] = '{1'b1, 16'h0008, 32'h0000_0003, 32'h0, 1'b0};
        vecs[12] = '{1'b1, 16'h000C, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 16'h000C, 32'h0, 32'h0000_0007, 1'b0};
        vecs[14] = '{1'b1, 16'h000C, 32'h0000_0002, 32'h0, 1'b0};
        vecs[15] = '{1'b1, 16'h0020, 32'h0001_0001, 32'h0, 1'b0};
        vecs[16] = '{1'b1, 16'h0024, 32'h0002_0002, 32'h0, 1'b0};
        vecs[17] = '{1'b1, 16'h0028, 32'h0000_0004, 32'h0, 1'b0};
        vecs[18] = '{1'b1, 16'h002C, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[19] = '{1'b1, 16'h0010, 32'h0000_005A, 32'h0, 1'b0};
        vecs[20] = '{1'b1, 16'h0000, 32'h0000_001C, 32'h0, 1'b0};
        vecs[21] = '{1'b0, 16'h0000, 32'h0, 32'h0000_001C, 1'b0};
        vecs[22] = '{1'b1, 16'h0000, 32'h0000_0000, 32'h0, 1'b0};
        vecs[23] = '{1'b1, 16'h0014, 32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[24] = '{1'b0, 16'h0008, 32'h0, 32'h0000_0003, 1'b0};
        vecs[25] = '{1'b0, 16'h000C, 32'h0, 32'h0000_0002, 1'b0};
        vecs[26] = '{1'b0, 16'h0020, 32'h0, 32'h0001_0001, 1'b0};
        vecs[27] = '{1'b0, 16'h0024, 32'h0, 32'h0002_0002, 1'b0};
        vecs[28] = '{1'b0, 16'h0028, 32'h0, 32'h0000_0004, 1'b0};
        vecs[29] = '{1'b0, 16'h002C, 32'h0, 32'h00FF_00FF, 1'b0};
        vecs[30] = '{1'b0, 16'h0010, 32'h0, 32'h0000_005A, 1'b0};
        vecs[31] = '{1'b0, 16'h0014, 32'h0, 32'h0000_0000, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_o_led", {24'h0, o_led}, 32'h0);
        check("reset_o_irq", {31'h0, o_irq}, 32'h0);
        check("reset_prdata", apb.prdata, 32'h0);
        check("reset_pslverror", {31'h0, apb.pslverror}, 32'h0);
        check("reset_pready", {31'h0, apb.pready}, 32'h1);
        rst = 1'b0;
        @(negedge clk);

        run_vecs(0, 8);
        run_vecs(9, 31);
        check("idle_led_follow", {24'h0, o_led}, 32'h5A);

        // One-shot: 0x01 x4, 0x02 x8, 0x04 x4, then IDLE_LED with done/irq.
        apb_write(16'h0000, 32'h0000_0011);
        for (int k = 0; k <= 16; k++) begin
            exp_led = (k < 4) ? 8'h01 : (k < 12) ? 8'h02 : (k < 16) ? 8'h04 : 8'h5A;
            check($sformatf("oneshot_led_k%0d", k), {24'h0, o_led}, {24'h0, exp_led});
            if (k == 15) check("oneshot_irq_before_end", {31'h0, o_irq}, 32'h0);
            if (k == 16) check("oneshot_irq_at_end", {31'h0, o_irq}, 32'h1);
            if (k < 16) @(negedge clk);
        end
        read_status_masked("oneshot_status_done", 32'h3, 32'h2);
        apb_write(16'h0004, 32'h0000_0002);
        check("w1c_irq_clear", {31'h0, o_irq}, 32'h0);
        read_status_masked("w1c_status", 32'h3, 32'h0);

        // Loop mode, then stop mid-entry.
        apb_write(16'h0000, 32'h0000_0015);
        for (int k = 0; k < 20; k++) begin
            exp_led = ((k % 16) < 4) ? 8'h01 : ((k % 16) < 12) ? 8'h02 : 8'h04;
            check($sformatf("loop_led_k%0d", k), {24'h0, o_led}, {24'h0, exp_led});
            if (k < 19) @(negedge clk);
        end
        apb_write(16'h0000, 32'h0000_0016);
        check("stop_led_idle", {24'h0, o_led}, 32'h5A);
        check("stop_irq", {31'h0, o_irq}, 32'h0);
        read_status_masked("stop_status", 32'h3, 32'h0);

        // start and stop together: no run.
        apb_write(16'h0000, 32'h0000_0013);
        check("startstop_led", {24'h0, o_led}, 32'h5A);
        read_status_masked("startstop_busy", 32'h3, 32'h0);

        // Restart while running.
        apb_write(16'h0000, 32'h0000_0005);
        repeat (6) @(negedge clk);
        check("restart_pre_led", {24'h0, o_led}, 32'h02);
        apb_write(16'h0000, 32'h0000_0005);
        check("restart_led", {24'h0, o_led}, 32'h01);
        read_status_masked("restart_status", 32'hFFFF_FFFF, 32'h0000_0001);
        apb_write(16'h0000, 32'h0000_0002);
        check("restart_stop_led", {24'h0, o_led}, 32'h5A);

        // Lower LAST from 3 to 0 while idx = 2: run ends after entry 2.
        apb_write(16'h002C, 32'h0001_0008);
        apb_write(16'h000C, 32'h0000_0003);
        apb_write(16'h0000, 32'h0000_0011);
        repeat (12) @(negedge clk);
        check("lastlow_entry2", {24'h0, o_led}, 32'h04);
        apb_write(16'h000C, 32'h0000_0000);
        check("lastlow_k14", {24'h0, o_led}, 32'h04);
        @(negedge clk);
        check("lastlow_k15", {24'h0, o_led}, 32'h04);
        @(negedge clk);
        check("lastlow_end_led", {24'h0, o_led}, 32'h5A);
        check("lastlow_end_irq", {31'h0, o_irq}, 32'h1);
        apb_write(16'h0004, 32'h0000_0002);
        apb_write(16'h000C, 32'h0000_0002);

        // Reset in the middle of a looping run.
        apb_write(16'h0000, 32'h0000_0015);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_led", {24'h0, o_led}, 32'h0);
        check("midreset_irq", {31'h0, o_irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        run_vecs(0, 8);

        // Switch trigger: 1-cycle entry of 0x80 per start.
        apb_write(16'h0008, 32'h0000_0000);
        apb_write(16'h0020, 32'h0001_0080);
        apb_write(16'h0000, 32'h0000_0008);
        repeat (2) @(negedge clk);
        sw_base = sw_run_cnt;
        i_sw = 1'b1;
        repeat (3) @(negedge clk);
        i_sw = 1'b0;
        repeat (12) @(negedge clk);
        check("sw_short_pulse", sw_run_cnt - sw_base, 32'd0);

        i_sw = 1'b1;
        repeat (10) @(negedge clk);
        i_sw = 1'b0;
        repeat (2) @(negedge clk);
        i_sw = 1'b1;
        repeat (2) @(negedge clk);
        i_sw = 1'b0;
        repeat (2) @(negedge clk);
        i_sw = 1'b1;
        repeat (2) @(negedge clk);
        i_sw = 1'b0;
        repeat (12) @(negedge clk);
        check("sw_hold_one_start", sw_run_cnt - sw_base, 32'd1);

        apb_write(16'h0000, 32'h0000_0000);
        i_sw = 1'b1;
        repeat (10) @(negedge clk);
        i_sw = 1'b0;
        repeat (12) @(negedge clk);
        check("sw_disabled", sw_run_cnt - sw_base, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_led_sequencer.md
Name: apb_led_sequencer

Overview:
- APB3 slave peripheral on the SoC's io_apbSlave_0 window (16-bit address, 32-bit data).
- Controls and schedules the 8-bit LED bank: it steps through a programmable table of up to 8 LED patterns, each held for a programmable duration, in one-shot or loop mode.
- A run can be started by firmware or, when enabled, by a debounced press of the board switch.
- Raises a done flag and an optional interrupt at the end of a one-shot run.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, number of consecutive stable synchronized samples of i_sw required to accept a level change.
- PRESCALE_RESET, 24'd49999, reset value of the PRESCALE register.

Ports:
- io_systemClk  input  1  system clock; all logic is on this clock.
- io_systemReset  input  1  synchronous, active-high reset.
- io_apbSlave_0_PADDR  input  16  APB address; byte address, bits [1:0] ignored.
- io_apbSlave_0_PSEL  input  1  APB select.
- io_apbSlave_0_PENABLE  input  1  APB access phase.
- io_apbSlave_0_PWRITE  input  1  1 = write.
- io_apbSlave_0_PWDATA  input  32  write data.
- io_apbSlave_0_PRDATA  output  32  read data, valid in the access phase.
- io_apbSlave_0_PREADY  output  1  always 1 (zero wait states).
- io_apbSlave_0_PSLVERROR  output  1  1 in the access phase for an unmapped address.
- i_sw  input  1  asynchronous switch; active high.
- o_led  output  8  registered LED drive.
- o_irq  output  1  level interrupt = STATUS.done & CTRL.irq_en.

Behaviour:
- Reset state:
  - FSM = IDLE, idx = 0, o_led = 0, o_irq = 0.
  - All registers = 0, except PRESCALE = PRESCALE_RESET.
  - PRDATA = 0, PSLVERROR = 0.
- APB transfer rules:
  - A transfer is PSEL & PENABLE. Writes commit on that clock edge.
  - Reads are a combinational decode of PADDR; PRDATA = 0 outside the access phase and for unmapped addresses.
  - PSLVERROR = PSEL & PENABLE & unmapped. Writes to unmapped addresses are ignored.
- Register map:
  - 0x00 CTRL (RW): bit0 start (write-1 pulse, reads 0); bit1 stop (write-1 pulse, reads 0); bit2 loop; bit3 sw_trig_en; bit4 irq_en.
  - 0x04 STATUS: bit0 busy (RO); bit1 done (W1C); bits[6:4] current idx (RO).
  - 0x08 PRESCALE [23:0] (RW).
  - 0x0C LAST [2:0] (RW): index of the last table entry; the table has LAST+1 entries.
  - 0x10 IDLE_LED [7:0] (RW): LED value driven while in IDLE.
  - 0x20 + 4*i, for i = 0..7, PAT[i] (RW): [7:0] led value; [23:16] dur.
- Timing:
  - One tick = PRESCALE+1 cycles.
  - An entry is held for max(dur,1) ticks, i.e. exactly (PRESCALE+1)*max(dur,1) cycles.
- FSM IDLE:
  - o_led follows IDLE_LED (registered, one cycle after a write).
  - A start event moves to RUN on the same edge: idx <= 0, o_led <= PAT[0].led, prescale counter and tick counter loaded.
  - Start events are a CTRL write with start=1 and stop=0, or a debounced i_sw rising edge while sw_trig_en = 1.
- FSM RUN:
  - busy = 1.
  - On the last cycle of the current entry:
    - If idx != LAST: idx <= idx+1 and o_led <= PAT[idx+1].led.
    - Else if loop = 1: idx <= 0 and o_led <= PAT[0].led.
    - Else: go to IDLE, set done, o_led <= IDLE_LED.
  - A start event in RUN restarts at idx 0.
  - A stop moves to IDLE immediately without setting done.
- Live edits:
  - PAT writes during RUN take effect when that entry is next loaded.
  - PRESCALE writes take effect at the next counter reload.
  - LAST writes take effect at the next end-of-entry comparison.
  - If LAST is lowered below the current idx, the sequence ends or wraps at the end of the current entry.
- Simultaneous events:
  - stop wins over start in the same write.
  - stop wins over a switch trigger in the same cycle.
  - A done set wins over a W1C clear in the same cycle.
  - Reset asserted mid-run forces the reset state on that edge.
- Switch path:
  - 2-flop synchronizer followed by the DEBOUNCE_CYCLES stability counter.
  - Only a debounced 0->1 transition is a trigger.
  - The debounced level resets to 0.

Test Plan:
- APB basics: write PRESCALE = 3, LAST = 2, PAT0..2 = {0x01,dur1}, {0x02,dur2}, {0x04,dur0}; read all back; read 0x14 -> PRDATA = 0, PSLVERROR = 1 in the access phase, PREADY = 1 throughout.
- One-shot run: write CTRL start, loop = 0, irq_en = 1 -> o_led shows 0x01 for 4 cycles, 0x02 for 8, 0x04 for 4, then IDLE_LED; STATUS.done = 1 and o_irq = 1 on the same edge; W1C done -> o_irq = 0.
- Loop mode with stop: loop = 1 -> sequence 0x01, 0x02, 0x04, 0x01… continues; write stop mid-entry -> o_led = IDLE_LED on the next edge, busy = 0, done stays 0.
- Boundaries:
  - Write start|stop together -> stays IDLE.
  - Start during RUN -> idx returns to 0 on the write edge.
  - Lower LAST to 0 while idx = 2 -> run ends after the current entry.
  - Reset mid-run -> o_led = 0, all registers at reset values.
- Switch trigger (DEBOUNCE_CYCLES = 4 in the bench):
  - sw_trig_en = 1; pulse i_sw for 3 cycles -> no start.
  - Hold i_sw for 10 cycles -> exactly one start; a release and bounce shorter than 4 cycles -> no retrigger.
  - sw_trig_en = 0 -> no start.
